sfr_pwm_bank: RTL

Parametrised successor to the fixed three-channel PWM section of the SFR block. It is a memory-mapped bank of N complementary PWM channels sharing one prescaler and one period counter. Duty, period and dead time are double-buffered and committed only at a period boundary, and a sticky wrap flag is provided. It sits on the CPU's 8-bit SFR bus beside the other peripherals and drives gate-driver pins.

---
 rtl/sfr_pwm_pkg.sv | 17 +
 rtl/sfr_pwm_bank_if.sv | 12 +
 rtl/pwm_channel.sv | 43 ++++
 rtl/sfr_pwm_bank.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sfr_pwm_pkg.sv
// Register map and bit positions shared by the PWM bank and its channels.
package sfr_pwm_pkg;

    // Register offsets from the bank's base address
    localparam logic [7:0] OFF_CTRL     = 8'd0;
    localparam logic [7:0] OFF_PRESC    = 8'd1;
    localparam logic [7:0] OFF_PERIOD   = 8'd2;
    localparam logic [7:0] OFF_DEADTIME = 8'd3;
    localparam logic [7:0] OFF_STATUS   = 8'd4;
    localparam logic [7:0] OFF_DUTY0    = 8'd5;

    // CTRL / STATUS bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_UPD_BIT    = 1;
    localparam int STATUS_WRAP_BIT = 0;

endpackage

// File: rtl/sfr_pwm_bank_if.sv
// SFR bus as seen by the PWM bank: one-cycle write strobe, registered read data.
interface sfr_pwm_bank_if #(
    parameter int DATA_W = 8
) ();
    logic [7:0]        addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/pwm_channel.sv
// One complementary PWM channel: raw compare, dead-time counter, output flops.
module pwm_channel #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tick,
    input  logic [DATA_W-1:0] cnt,
    input  logic [DATA_W-1:0] duty,
    input  logic [DATA_W-1:0] dead,
    output logic              pwm_h,
    output logic              pwm_l
);
    logic              raw, raw_q, raw_edge, gate;
    logic [DATA_W-1:0] dcnt, dcnt_eff;

    // dcnt reads as 0 in the cycle of a raw edge so the gap starts right at the edge
    assign raw      = cnt < duty;
    assign raw_edge = raw ^ raw_q;
    assign dcnt_eff = raw_edge ? '0 : dcnt;
    assign gate     = dcnt_eff >= dead;

    // Track raw, count ticks since the last edge (saturating), register the gated pins
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= 1'b0;
            dcnt  <= '0;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else begin
            raw_q <= raw;
            if (!en)
                dcnt <= '0;
            else if (tick && dcnt_eff != '1)
                dcnt <= dcnt_eff + DATA_W'(1);
            else
                dcnt <= dcnt_eff;
            pwm_h <= en & raw & gate;
            pwm_l <= en & ~raw & gate;
        end
    end
endmodule

// File: rtl/sfr_pwm_bank.sv
// Bank of N_CH complementary PWM channels on the SFR bus: shared prescaler and
// period counter, double-buffered period/dead/duty committed at a wrap.
module sfr_pwm_bank
    import sfr_pwm_pkg::*;
#(
    parameter int         N_CH      = 3,
    parameter int         DATA_W    = 8,
    parameter logic [7:0] ADDR_BASE = 8'h10
) (
    input  logic             clk,
    input  logic             rst,
    sfr_pwm_bank_if.slave    bus,
    output logic [N_CH-1:0]  pwm_h,
    output logic [N_CH-1:0]  pwm_l
);
    logic [7:0]                   off;
    logic                         en, upd_pend, wrap;
    logic [DATA_W-1:0]            presc, per_sh, per_act, dead_sh, dead_act;
    logic [DATA_W-1:0]            pcnt, cnt, rd_val;
    logic [N_CH-1:0][DATA_W-1:0]  duty_sh, duty_act;
    logic                         tick, wrap_ev, commit;
    logic                         wr_ctrl, wr_presc, wr_per, wr_dead, wr_stat;
    logic [N_CH-1:0]              wr_duty;

    // Addresses below the base wrap to large offsets and match no register
    assign off      = bus.addr - ADDR_BASE;
    assign wr_ctrl  = bus.we && off == OFF_CTRL;
    assign wr_presc = bus.we && off == OFF_PRESC;
    assign wr_per   = bus.we && off == OFF_PERIOD;
    assign wr_dead  = bus.we && off == OFF_DEADTIME;
    assign wr_stat  = bus.we && off == OFF_STATUS;

    assign tick    = en && pcnt == presc;
    assign wrap_ev = tick && cnt == per_act;
    assign commit  = wrap_ev && upd_pend;

    // Per-channel duty write strobes
    always_comb begin
        wr_duty = '0;
        for (int i = 0; i < N_CH; i++)
            wr_duty[i] = bus.we && off == OFF_DUTY0 + 8'(i);
    end

    // Read mux: shadow values, out-of-window offsets read as 0
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_CTRL: begin
                rd_val[CTRL_EN_BIT]  = en;
                rd_val[CTRL_UPD_BIT] = upd_pend;
            end
            OFF_PRESC:    rd_val = presc;
            OFF_PERIOD:   rd_val = per_sh;
            OFF_DEADTIME: rd_val = dead_sh;
            OFF_STATUS:   rd_val[STATUS_WRAP_BIT] = wrap;
            default: ;
        endcase
        for (int i = 0; i < N_CH; i++)
            if (off == OFF_DUTY0 + 8'(i)) rd_val = duty_sh[i];
    end

    // Register file: shadows, commit into actives at a wrap, direct update while stopped
    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            upd_pend <= 1'b0;
            wrap     <= 1'b0;
            presc    <= '0;
            per_sh   <= '0;
            per_act  <= '0;
            dead_sh  <= '0;
            dead_act <= '0;
            duty_sh  <= '0;
            duty_act <= '0;
            bus.rdata <= '0;
        end else begin
            bus.rdata <= rd_val;
            if (wr_ctrl) en <= bus.wdata[CTRL_EN_BIT];
            // A request landing on a wrap waits for the following wrap
            if (wr_ctrl && bus.wdata[CTRL_UPD_BIT]) upd_pend <= 1'b1;
            else if (commit)                        upd_pend <= 1'b0;
            // Set beats a same-cycle clear
            if (wrap_ev)                                   wrap <= 1'b1;
            else if (wr_stat && bus.wdata[STATUS_WRAP_BIT]) wrap <= 1'b0;
            if (wr_presc) presc <= bus.wdata;
            if (wr_per)   per_sh <= bus.wdata;
            if (wr_dead)  dead_sh <= bus.wdata;
            // Commit copies the pre-edge shadow, so a same-cycle write waits for the next one
            if (commit)              per_act <= per_sh;
            else if (!en && wr_per)  per_act <= bus.wdata;
            if (commit)              dead_act <= dead_sh;
            else if (!en && wr_dead) dead_act <= bus.wdata;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_duty[i]) duty_sh[i] <= bus.wdata;
                if (commit)                  duty_act[i] <= duty_sh[i];
                else if (!en && wr_duty[i])  duty_act[i] <= bus.wdata;
            end
        end
    end

    // Prescaler and period counter, parked at 0 while disabled
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pcnt <= '0;
            cnt  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + DATA_W'(1);
            if (wrap_ev)   cnt <= '0;
            else if (tick) cnt <= cnt + DATA_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_channel #(.DATA_W(DATA_W)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .tick  (tick),
            .cnt   (cnt),
            .duty  (duty_act[g]),
            .dead  (dead_act),
            .pwm_h (pwm_h[g]),
            .pwm_l (pwm_l[g])
        );
    end
endmodule
